// File: rtl/fm_fft_pkg.sv
// Shared types and helpers for the FM FFT frame feeder: sample layout,
// feeder FSM states and the point-counter sizing rule.
package fm_fft_pkg;

    localparam int DEFAULT_DATA_W = 22;

    typedef struct packed {
        logic signed [DEFAULT_DATA_W-1:0] re;
        logic signed [DEFAULT_DATA_W-1:0] im;
    } sample_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } feeder_state_t;

    function automatic int pt_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/fm_fft_frame_feeder_if.sv
// Avalon-ST link between the frame feeder (master) and the FFT sink port (slave).
interface fm_fft_frame_feeder_if
    import fm_fft_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    logic                  valid;
    logic                  ready;
    logic [1:0]            error;
    logic                  startofpacket;
    logic                  endofpacket;
    logic [2*DATA_W-1:0]   data;

    modport master (
        output valid, error, startofpacket, endofpacket, data,
        input  ready
    );

    modport slave (
        input  valid, error, startofpacket, endofpacket, data,
        output ready
    );
endinterface

// File: rtl/fm_fft_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry sits in a register
// so rd_data is valid one cycle after the write that made the FIFO non-empty.
module fm_fft_sample_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [AW:0]      count;
    logic [AW:0]      count_after_rd;
    logic             push;
    logic             pop;

    // Full is judged on the pre-read count, so a same-cycle pop never makes room.
    assign full           = (count == (AW+1)'(DEPTH));
    assign empty          = (count == '0);
    assign push           = wr_req && !full;
    assign pop            = rd_en && !empty;
    assign rd_ptr_nxt     = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign count_after_rd = pop ? count - 1'b1 : count;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr_nxt;
            count  <= count_after_rd + (AW+1)'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The head register only moves when a new entry becomes the head.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (!flush) begin
            if (push && count_after_rd == '0) begin
                rd_data <= wr_data;
            end else if (pop && count_after_rd != '0) begin
                rd_data <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/fm_fft_frame_feeder.sv
// Buffers the continuous FM sample stream and delivers fixed-length
// SOP/EOP-framed bursts to the FFT sink under its ready handshake.
module fm_fft_frame_feeder
    import fm_fft_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset,
    input  logic                     enable,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic                     stat_clr,
    fm_fft_frame_feeder_if.master    fft_ii_0_sink,
    output logic                     overflow,
    output logic [15:0]              frame_count,
    output logic                     busy
);
    localparam int PT_W = pt_width(FRAME_LEN);

    feeder_state_t       state;
    logic [PT_W-1:0]     pt;
    logic                flush;
    logic                wr_req;
    logic                full;
    logic                empty;
    logic                xfer;
    logic                last_point;
    logic [2*DATA_W-1:0] head;

    // Idle with enable low discards everything so each frame starts fresh.
    assign flush      = (state == IDLE) && !enable;
    assign wr_req     = in_valid && !flush;
    assign last_point = (pt == PT_W'(FRAME_LEN-1));
    assign xfer       = fft_ii_0_sink.valid && fft_ii_0_sink.ready;

    fm_fft_sample_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .flush   (flush),
        .wr_req  (wr_req),
        .wr_data ({in_real, in_imag}),
        .rd_en   (xfer),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign fft_ii_0_sink.valid         = (state == STREAM) && !empty;
    assign fft_ii_0_sink.startofpacket = (state == STREAM) && (pt == '0);
    assign fft_ii_0_sink.endofpacket   = (state == STREAM) && last_point;
    assign fft_ii_0_sink.data          = head;
    assign fft_ii_0_sink.error         = 2'b00;
    assign busy                        = (state == STREAM);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            pt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= STREAM;
                        pt    <= '0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (last_point) begin
                            pt <= '0;
                            if (!enable) begin
                                state <= IDLE;
                            end
                        end else begin
                            pt <= pt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    pt    <= '0;
                end
            endcase
        end
    end

    // A clear in the same cycle as an overflow or frame completion wins.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || stat_clr) begin
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (wr_req && full) begin
                overflow <= 1'b1;
            end
            if (xfer && last_point) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fm_fft_frame_feeder.sv
// Randomised scoreboard bench for fm_fft_frame_feeder with FRAME_LEN=8, FIFO_DEPTH=4;
// a queue-based reference model predicts beats and statistics every cycle.
module tb_fm_fft_frame_feeder;
    import fm_fft_pkg::*;

    localparam int DW = DEFAULT_DATA_W;
    localparam int FL = 8;
    localparam int FD = 4;

    logic                 clk      = 1'b0;
    logic                 reset    = 1'b1;
    logic                 enable   = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 stat_clr = 1'b0;
    logic signed [DW-1:0] in_real  = '0;
    logic signed [DW-1:0] in_imag  = '0;
    logic                 overflow;
    logic [15:0]          frame_count;
    logic                 busy;

    fm_fft_frame_feeder_if #(.DATA_W(DW)) sink_if ();

    fm_fft_frame_feeder #(
        .DATA_W     (DW),
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_clk       (clk),
        .reset_reset   (reset),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_real       (in_real),
        .in_imag       (in_imag),
        .stat_clr      (stat_clr),
        .fft_ii_0_sink (sink_if),
        .overflow      (overflow),
        .frame_count   (frame_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp      = 0;
    int n_fail     = 0;
    int beat_count = 0;
    bit armed      = 1'b0;

    // Reference model state: sample queue, streaming flag, point index, statistics.
    sample_t           m_q[$];
    logic [2*DW+1:0]   exp_q[$];
    bit                m_stream = 1'b0;
    int                m_pt     = 0;
    logic [15:0]       m_frames = '0;
    bit                m_ovf    = 1'b0;
    bit                cur_valid  = 1'b0;
    bit                cur_busy   = 1'b0;
    logic [15:0]       cur_frames = '0;
    bit                cur_ovf    = 1'b0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_edge();
        @(negedge clk);
        #3;
    endtask

    task automatic apply_stimulus(input logic v, input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
        in_valid = v;
        in_real  = re;
        in_imag  = im;
    endtask

    task automatic apply_random();
        apply_stimulus(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            apply_random();
            tick();
            n++;
        end
        apply_stimulus(1'b0, '0, '0);
        check_output(name, 64'(busy), 64'(0));
    endtask

    task automatic check_reset_values(input string tag);
        sample_edge();
        check_output({tag, "_valid"}, 64'(sink_if.valid), 64'(0));
        check_output({tag, "_sop"}, 64'(sink_if.startofpacket), 64'(0));
        check_output({tag, "_eop"}, 64'(sink_if.endofpacket), 64'(0));
        check_output({tag, "_data"}, 64'(sink_if.data), 64'(0));
        check_output({tag, "_error"}, 64'(sink_if.error), 64'(0));
        check_output({tag, "_overflow"}, 64'(overflow), 64'(0));
        check_output({tag, "_frame_count"}, 64'(frame_count), 64'(0));
        check_output({tag, "_busy"}, 64'(busy), 64'(0));
        tick();
    endtask

    // Model predicts what the coming rising edge does, using the stable inputs.
    always @(negedge clk) begin
        sample_t s;
        bit      was_stream;
        bit      was_full;
        cur_valid  = m_stream && (m_q.size() > 0);
        cur_busy   = m_stream;
        cur_frames = m_frames;
        cur_ovf    = m_ovf;
        if (reset) begin
            m_stream = 1'b0;
            m_q.delete();
            m_pt     = 0;
            m_frames = '0;
            m_ovf    = 1'b0;
        end else begin
            was_stream = m_stream;
            was_full   = (m_q.size() == FD);
            if (cur_valid && sink_if.ready) begin
                s = m_q.pop_front();
                exp_q.push_back({s, m_pt == 0, m_pt == FL-1});
                if (m_pt == FL-1) begin
                    m_pt     = 0;
                    m_frames = m_frames + 16'd1;
                    if (!enable) m_stream = 1'b0;
                end else begin
                    m_pt++;
                end
            end
            if (!was_stream && !enable) begin
                m_q.delete();
            end else if (in_valid) begin
                if (was_full) begin
                    m_ovf = 1'b1;
                end else begin
                    s.re = in_real;
                    s.im = in_imag;
                    m_q.push_back(s);
                end
            end
            if (!was_stream && enable) begin
                m_stream = 1'b1;
                m_pt     = 0;
            end
            if (stat_clr) begin
                m_frames = '0;
                m_ovf    = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every observed transfer and tracks status.
    logic [2*DW+1:0] prev_beat  = '0;
    bit              prev_stall = 1'b0;
    always @(negedge clk) begin
        logic [2*DW+1:0] e;
        logic [2*DW+1:0] got;
        #2;
        if (armed) begin
            got = {sink_if.data, sink_if.startofpacket, sink_if.endofpacket};
            check_output("valid", 64'(sink_if.valid), 64'(cur_valid));
            check_output("busy", 64'(busy), 64'(cur_busy));
            check_output("frame_count", 64'(frame_count), 64'(cur_frames));
            check_output("overflow", 64'(overflow), 64'(cur_ovf));
            if (prev_stall) begin
                check_output("hold", 64'({sink_if.valid, got}), 64'({1'b1, prev_beat}));
            end
            if (!reset && sink_if.valid && sink_if.ready) begin
                beat_count++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL beat: got unexpected beat %0h, want none", got);
                end else begin
                    e = exp_q.pop_front();
                    check_output("beat", 64'(got), 64'(e));
                end
            end
            prev_stall = !reset && sink_if.valid && !sink_if.ready;
            prev_beat  = got;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit hit;
        sink_if.ready = 1'b0;
        reset = 1'b1;
        tick();
        armed = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("rst0");

        // Ramp frame: real=k, imag=-k with ready held high.
        $display("[TB] ramp frame");
        beat_count    = 0;
        sink_if.ready = 1'b1;
        enable        = 1'b1;
        for (int k = 0; k < FL; k++) begin
            apply_stimulus(1'b1, DW'(k), -DW'(k));
            tick();
        end
        apply_stimulus(1'b0, '0, '0);
        enable = 1'b0;
        wait_idle("ramp_idle", 50);
        sample_edge();
        check_output("ramp_beats", 64'(beat_count), 64'(FL));
        check_output("ramp_frames", 64'(frame_count), 64'(1));
        tick();

        $display("[TB] ready toggling");
        beat_count = 0;
        enable     = 1'b1;
        apply_random();
        tick();
        enable = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            sink_if.ready = ((n % 2) == 0);
            apply_random();
            tick();
            n++;
        end
        sink_if.ready = 1'b1;
        wait_idle("toggle_idle", 50);
        sample_edge();
        check_output("toggle_beats", 64'(beat_count), 64'(FL));
        check_output("toggle_frames", 64'(frame_count), 64'(2));
        tick();

        $display("[TB] overflow while stalled");
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        sample_edge();
        check_output("clr_overflow", 64'(overflow), 64'(0));
        check_output("clr_frames", 64'(frame_count), 64'(0));
        tick();
        beat_count    = 0;
        sink_if.ready = 1'b0;
        enable        = 1'b1;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, DW'(100 + k), -DW'(100 + k));
            tick();
        end
        apply_stimulus(1'b0, '0, '0);
        sample_edge();
        check_output("ovf_set", 64'(overflow), 64'(1));
        check_output("ovf_no_beats", 64'(beat_count), 64'(0));
        tick();
        sink_if.ready = 1'b1;
        enable        = 1'b0;
        wait_idle("ovf_idle", 100);
        sample_edge();
        check_output("ovf_beats", 64'(beat_count), 64'(FL));
        check_output("ovf_frames", 64'(frame_count), 64'(1));
        tick();

        $display("[TB] enable dropped mid-frame");
        beat_count = 0;
        enable     = 1'b1;
        n = 0;
        while (beat_count < 3 && n < 50) begin
            apply_stimulus(1'b1, DW'($urandom), DW'($urandom));
            tick();
            n++;
        end
        enable = 1'b0;
        wait_idle("drop_idle", 100);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(1'b1, DW'($urandom), DW'($urandom));
            sample_edge();
            check_output("drop_no_valid", 64'(sink_if.valid), 64'(0));
            tick();
        end
        apply_stimulus(1'b0, '0, '0);
        sample_edge();
        check_output("drop_beats", 64'(beat_count), 64'(FL));
        check_output("drop_frames", 64'(frame_count), 64'(2));
        tick();

        $display("[TB] reset mid-frame");
        beat_count = 0;
        enable     = 1'b1;
        n = 0;
        while (beat_count < 5 && n < 50) begin
            apply_stimulus(1'b1, DW'($urandom), DW'($urandom));
            tick();
            n++;
        end
        reset  = 1'b1;
        enable = 1'b0;
        apply_stimulus(1'b0, '0, '0);
        tick();
        reset = 1'b0;
        check_reset_values("rst_mid");
        beat_count = 0;
        enable     = 1'b1;
        apply_stimulus(1'b1, DW'(55), -DW'(55));
        tick();
        enable = 1'b0;
        wait_idle("post_rst_idle", 100);
        sample_edge();
        check_output("post_rst_beats", 64'(beat_count), 64'(FL));
        check_output("post_rst_frames", 64'(frame_count), 64'(1));
        tick();

        $display("[TB] stat_clr on eop transfer");
        sink_if.ready = 1'b0;
        enable        = 1'b1;
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(1'b1, DW'($urandom), DW'($urandom));
            tick();
        end
        apply_stimulus(1'b0, '0, '0);
        sample_edge();
        check_output("clr_pre_overflow", 64'(overflow), 64'(1));
        tick();
        sink_if.ready = 1'b1;
        enable        = 1'b0;
        hit = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            stat_clr = sink_if.valid && sink_if.endofpacket;
            hit      = hit | stat_clr;
            apply_stimulus(1'b1, DW'($urandom), DW'($urandom));
            tick();
            n++;
        end
        stat_clr = 1'b0;
        apply_stimulus(1'b0, '0, '0);
        check_output("clr_eop_seen", 64'(hit), 64'(1));
        sample_edge();
        check_output("clr_eop_frames", 64'(frame_count), 64'(0));
        check_output("clr_eop_overflow", 64'(overflow), 64'(0));
        check_output("clr_eop_busy", 64'(busy), 64'(0));
        tick();

        repeat (4) tick();
        check_output("sb_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
